if_fetch: RTL and testbench

Instruction fetch stage of the RV32 core: owns the program counter, issues word reads to instruction memory, buffers returned instructions in a small FIFO, and presents them with a valid/ready handshake to the decode stage (`inst_i` of the decoder). It accepts a redirect from execute and discards any fetches issued down the wrong path.

---
 rtl/if_fetch_pkg.sv | 26 ++
 rtl/if_fetch_if.sv | 30 +++
 rtl/if_fifo.sv | 56 +++++
 rtl/if_fetch.sv | 103 ++++++++++
 tb/tb_if_fetch.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/if_fetch_pkg.sv
// Shared widths, constants and small helpers for the instruction fetch stage.
// Imported by the fetch interface, the instruction buffer and the fetch top.
package if_fetch_pkg;

   localparam int DATA_WIDTH        = 32;
   localparam int INST_ADDR_WIDTH   = 32;
   localparam int IF_FIFO_MAX_DEPTH = 4;
   localparam int IF_CNT_W          = $clog2(IF_FIFO_MAX_DEPTH + 1);
   localparam int IF_PTR_W          = $clog2(IF_FIFO_MAX_DEPTH);

   localparam logic [DATA_WIDTH-1:0] INST_NOP = 32'h0000_0013;

   typedef logic [IF_CNT_W-1:0]        if_cnt_t;
   typedef logic [INST_ADDR_WIDTH-1:0] if_addr_t;
   typedef logic [DATA_WIDTH-1:0]      if_data_t;

   // Sequential fetch address; 32'hFFFF_FFFC rolls over to 0.
   function automatic if_addr_t pc_incr(input if_addr_t pc);
      return pc + 32'd4;
   endfunction

   function automatic if_addr_t word_align(input if_addr_t addr);
      return addr & ~32'h3;
   endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Fetch-stage bus bundle: instruction memory port, redirect from execute and
// the valid/ready instruction stream to decode.
interface if_fetch_if;
   import if_fetch_pkg::*;

   logic     imem_req_o;
   if_addr_t imem_addr_o;
   logic     imem_gnt_i;
   logic     imem_rvalid_i;
   if_data_t imem_rdata_i;
   logic     jump_i;
   if_addr_t jump_addr_i;
   logic     inst_valid_o;
   logic     inst_ready_i;
   if_data_t inst_o;
   if_addr_t inst_addr_o;

   modport master (
      output imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_addr_o,
      input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, jump_i, jump_addr_i,
             inst_ready_i
   );

   modport slave (
      input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_addr_o,
      output imem_gnt_i, imem_rvalid_i, imem_rdata_i, jump_i, jump_addr_i,
             inst_ready_i
   );

endinterface

// File: rtl/if_fifo.sv
// Instruction buffer: synchronous FIFO of {instruction, pc} pairs with
// push/pop/flush. Flush empties the buffer and takes priority over pop.
module if_fifo
   import if_fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic     clk,
   input  logic     rst,
   input  logic     push,
   input  if_data_t push_data,
   input  if_addr_t push_addr,
   input  logic     pop,
   input  logic     flush,
   output if_data_t head_data,
   output if_addr_t head_addr,
   output if_cnt_t  count,
   output logic     empty
);

   localparam logic [IF_PTR_W-1:0] LAST = IF_PTR_W'(DEPTH - 1);

   if_data_t            data_mem [IF_FIFO_MAX_DEPTH];
   if_addr_t            addr_mem [IF_FIFO_MAX_DEPTH];
   logic [IF_PTR_W-1:0] wr_ptr;
   logic [IF_PTR_W-1:0] rd_ptr;

   function automatic logic [IF_PTR_W-1:0] ptr_next(input logic [IF_PTR_W-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_next(wr_ptr);
         if (pop)  rd_ptr <= ptr_next(rd_ptr);
         count <= count + if_cnt_t'(push) - if_cnt_t'(pop);
      end
   end

   // Payload storage carries no reset; occupancy is tracked by count alone.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         data_mem[wr_ptr] <= push_data;
         addr_mem[wr_ptr] <= push_addr;
      end
   end

   assign head_data = data_mem[rd_ptr];
   assign head_addr = addr_mem[rd_ptr];
   assign empty     = (count == '0);

endmodule

// File: rtl/if_fetch.sv
// RV32 instruction fetch: PC, credit-limited memory requests, wrong-path
// discard after redirect. IF_PREFETCH_EN enables FIFO_DEPTH outstanding fetches.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter logic [INST_ADDR_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
   parameter int                         FIFO_DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst,
   if_fetch_if.master    bus
);

`ifdef IF_PREFETCH_EN
   localparam int DEPTH = FIFO_DEPTH;
`else
   // Fetch-one-at-a-time: one credit and a single buffer slot whatever FIFO_DEPTH says.
   localparam int DEPTH = (FIFO_DEPTH > 0) ? 1 : 1;
`endif

   if_addr_t pc_q,          pc_n;
   if_addr_t rsp_pc_q,      rsp_pc_n;
   if_cnt_t  outstanding_q, outstanding_n;
   if_cnt_t  discard_q,     discard_n;

   if_cnt_t           fifo_count;
   logic              fifo_empty;
   logic              fifo_push;
   logic              fifo_pop;
   if_data_t          head_data;
   if_addr_t          head_addr;
   logic [IF_CNT_W:0] in_use;
   logic              credit_ok;
   logic              gnt_fire;

   assign in_use    = {1'b0, outstanding_q} + {1'b0, fifo_count};
   assign credit_ok = (in_use < (IF_CNT_W + 1)'(DEPTH));

   assign bus.imem_req_o  = !rst && !bus.jump_i && credit_ok;
   assign bus.imem_addr_o = pc_q;
   assign gnt_fire        = bus.imem_req_o && bus.imem_gnt_i;

   assign fifo_push = bus.imem_rvalid_i && (discard_q == '0) && !bus.jump_i;
   assign fifo_pop  = bus.inst_valid_o && bus.inst_ready_i && !bus.jump_i;

   assign bus.inst_valid_o = !fifo_empty;
   assign bus.inst_o       = fifo_empty ? INST_NOP : head_data;
   assign bus.inst_addr_o  = fifo_empty ? RESET_PC : head_addr;

   always_comb begin
      pc_n          = pc_q;
      rsp_pc_n      = rsp_pc_q;
      outstanding_n = outstanding_q + if_cnt_t'(gnt_fire) - if_cnt_t'(bus.imem_rvalid_i);
      discard_n     = discard_q;

      if (gnt_fire)
         pc_n = pc_incr(pc_q);
      // Responses return in order, so the PC of the next kept response is sequential.
      if (fifo_push)
         rsp_pc_n = pc_incr(rsp_pc_q);
      if (bus.imem_rvalid_i && (discard_q != '0))
         discard_n = discard_q - 1'b1;

      // Responses already marked for discard are still part of outstanding, so
      // after a redirect every response still in flight is dropped exactly once.
      if (bus.jump_i) begin
         pc_n      = word_align(bus.jump_addr_i);
         rsp_pc_n  = word_align(bus.jump_addr_i);
         discard_n = outstanding_q - if_cnt_t'(bus.imem_rvalid_i);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         rsp_pc_q      <= RESET_PC;
         outstanding_q <= '0;
         discard_q     <= '0;
      end else begin
         pc_q          <= pc_n;
         rsp_pc_q      <= rsp_pc_n;
         outstanding_q <= outstanding_n;
         discard_q     <= discard_n;
      end
   end

   if_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (fifo_push),
      .push_data (bus.imem_rdata_i),
      .push_addr (rsp_pc_q),
      .pop       (fifo_pop),
      .flush     (bus.jump_i),
      .head_data (head_data),
      .head_addr (head_addr),
      .count     (fifo_count),
      .empty     (fifo_empty)
   );

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: in-order memory model with switchable grant and
// response, tracking of granted and delivered PCs against hand-set expectations.
module tb_if_fetch;
   import if_fetch_pkg::*;

`ifdef IF_PREFETCH_EN
   localparam int DEP = 2;
`else
   localparam int DEP = 1;
`endif

   logic clk;
   logic rst;
   int   n_vec;
   int   n_err;
   int   n_deliv;
   int   d0;
   logic gnt_en;
   logic rsp_en;
   logic [31:0] exp_pc;
   logic [31:0] exp_req;
   logic [31:0] mq [$];

   if_fetch_if bus ();

   if_fetch #(
      .RESET_PC   (32'h0000_0000),
      .FIFO_DEPTH (2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] img(input logic [31:0] a);
      return a ^ 32'hCAFE_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive_mem();
      bus.imem_gnt_i = gnt_en;
      if (mq.size() != 0 && rsp_en) begin
         bus.imem_rvalid_i = 1'b1;
         bus.imem_rdata_i  = img(mq[0]);
      end else begin
         bus.imem_rvalid_i = 1'b0;
         bus.imem_rdata_i  = 32'h0;
      end
   endtask

   task automatic settle();
      drive_mem();
      #1;
   endtask

   task automatic tick();
      logic        f_req;
      logic        f_rv;
      logic [31:0] a;
      f_req = bus.imem_req_o && bus.imem_gnt_i;
      f_rv  = bus.imem_rvalid_i;
      a     = bus.imem_addr_o;
      n_vec++;
      assert (!(dut.fifo_push && (32'(dut.fifo_count) == DEP))) else begin
         n_err++;
         $error("FAIL fifo_overflow: observed push into count %0d expected no push", dut.fifo_count);
      end
      @(posedge clk);
      #1;
      if (f_rv && mq.size() != 0) void'(mq.pop_front());
      if (f_req) mq.push_back(a);
      drive_mem();
      #1;
   endtask

   task automatic track();
      if (bus.imem_req_o && bus.imem_gnt_i) begin
         check("req_addr", bus.imem_addr_o, exp_req);
         exp_req = exp_req + 32'd4;
      end
      if (bus.inst_valid_o && bus.inst_ready_i) begin
         check("inst_addr", bus.inst_addr_o, exp_pc);
         check("inst_data", bus.inst_o, img(exp_pc));
         exp_pc = exp_pc + 32'd4;
         n_deliv++;
      end
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         track();
         tick();
      end
   endtask

   initial begin
      n_vec = 0; n_err = 0; n_deliv = 0; d0 = 0;
      rst = 1'b1;
      gnt_en = 1'b1; rsp_en = 1'b1;
      bus.jump_i = 1'b0; bus.jump_addr_i = 32'h0; bus.inst_ready_i = 1'b1;
      exp_pc = 32'h0; exp_req = 32'h0;
      settle();
      repeat (3) tick();

      // Reset state
      check("rst_req", 32'(bus.imem_req_o), 32'd0);
      check("rst_addr", bus.imem_addr_o, 32'h0);
      check("rst_valid", 32'(bus.inst_valid_o), 32'd0);
      check("rst_inst", bus.inst_o, 32'h0000_0013);
      check("rst_inst_addr", bus.inst_addr_o, 32'h0);

      // Streaming: first request right after reset, first instruction two cycles later
      rst = 1'b0;
      settle();
      check("first_req", 32'(bus.imem_req_o), 32'd1);
      check("first_addr", bus.imem_addr_o, 32'h0);
      track(); tick();
      check("lat_valid_c1", 32'(bus.inst_valid_o), 32'd0);
      track(); tick();
      check("lat_valid_c2", 32'(bus.inst_valid_o), 32'd1);
      check("lat_addr_c2", bus.inst_addr_o, 32'h0);
      run(20);

      // Backpressure
      bus.inst_ready_i = 1'b0;
      settle();
      run(10);
      check("bp_req", 32'(bus.imem_req_o), 32'd0);
      check("bp_credit", 32'(dut.outstanding_q) + 32'(dut.fifo_count), DEP);
      check("bp_valid", 32'(bus.inst_valid_o), 32'd1);
      check("bp_head", bus.inst_addr_o, exp_pc);
      bus.inst_ready_i = 1'b1;
      settle();
      run(12);
      gnt_en = 1'b0;
      settle();
      run(6);
      check("drain_valid", 32'(bus.inst_valid_o), 32'd0);
      check("drain_out", 32'(dut.outstanding_q), 32'd0);

      // Redirect with fetches in flight
      gnt_en = 1'b1; rsp_en = 1'b0;
      settle();
      run(DEP);
      check("inflight_out", 32'(dut.outstanding_q), DEP);
      check("inflight_req", 32'(bus.imem_req_o), 32'd0);
      bus.jump_i = 1'b1; bus.jump_addr_i = 32'h0000_0103;
      settle();
      check("jump_mask_req", 32'(bus.imem_req_o), 32'd0);
      tick();
      bus.jump_i = 1'b0;
      rsp_en = 1'b1;
      settle();
      check("jump_pc", bus.imem_addr_o, 32'h0000_0100);
      check("jump_discard", 32'(dut.discard_q), DEP);
      exp_pc = 32'h100; exp_req = 32'h100;
      d0 = n_deliv;
      run(12);
      check("jump_delivered", 32'(n_deliv > d0), 32'd1);
      gnt_en = 1'b0;
      settle();
      run(6);

      // Redirect colliding with a response and a decode handshake
      gnt_en = 1'b1; rsp_en = 1'b1; bus.inst_ready_i = 1'b0;
      settle();
`ifdef IF_PREFETCH_EN
      run(2);
      check("coll_valid", 32'(bus.inst_valid_o), 32'd1);
`else
      run(1);
`endif
      check("coll_rvalid", 32'(bus.imem_rvalid_i), 32'd1);
      bus.inst_ready_i = 1'b1; bus.jump_i = 1'b1; bus.jump_addr_i = 32'h0000_0200;
      settle();
      check("coll_mask_req", 32'(bus.imem_req_o), 32'd0);
      tick();
      bus.jump_i = 1'b0;
      settle();
      check("coll_empty", 32'(bus.inst_valid_o), 32'd0);
      check("coll_discard", 32'(dut.discard_q), 32'd0);
      check("coll_req", 32'(bus.imem_req_o), 32'd1);
      check("coll_addr", bus.imem_addr_o, 32'h0000_0200);
      exp_pc = 32'h200; exp_req = 32'h200;
      track(); tick();
      track();
      check("coll_n2_valid", 32'(bus.inst_valid_o), 32'd0);
      tick();
      check("coll_n3_valid", 32'(bus.inst_valid_o), 32'd1);
      check("coll_n3_addr", bus.inst_addr_o, 32'h0000_0200);
      run(6);
      gnt_en = 1'b0;
      settle();
      run(6);

      // Wrap-around of the PC
      gnt_en = 1'b1;
      bus.jump_i = 1'b1; bus.jump_addr_i = 32'hFFFF_FFFC;
      settle();
      tick();
      bus.jump_i = 1'b0;
      settle();
      exp_pc = 32'hFFFF_FFFC; exp_req = 32'hFFFF_FFFC;
      check("wrap_req", 32'(bus.imem_req_o), 32'd1);
      check("wrap_addr0", bus.imem_addr_o, 32'hFFFF_FFFC);
      track(); tick();
      check("wrap_addr1", bus.imem_addr_o, 32'h0000_0000);
      run(8);

      // Reset with a full buffer
      bus.inst_ready_i = 1'b0;
      settle();
      run(8);
      check("mid_count", 32'(dut.fifo_count), DEP);
      rst = 1'b1;
      settle();
      check("mid_rst_req", 32'(bus.imem_req_o), 32'd0);
      tick();
      mq.delete();
      settle();
      check("mid_valid", 32'(bus.inst_valid_o), 32'd0);
      check("mid_inst", bus.inst_o, 32'h0000_0013);
      check("mid_inst_addr", bus.inst_addr_o, 32'h0);
      check("mid_addr", bus.imem_addr_o, 32'h0);
      rst = 1'b0; bus.inst_ready_i = 1'b1;
      exp_pc = 32'h0; exp_req = 32'h0;
      settle();
      d0 = n_deliv;
      run(10);
      check("post_rst_delivered", 32'(n_deliv > d0), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
